// File: rtl/vga_capture_pkg.sv
// Shared definitions for the VGA frame capture block: FSM encoding,
// FIFO entry width and the colour channel expansion helper.
package vga_capture_pkg;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // FIFO entry layout: {sof, eof, r[7:0], g[7:0], b[7:0]}
  localparam int ENTRY_W = 26;

  // Expand a 'bits'-wide channel (held in raw[bits-1:0]) to 8 bits by
  // repeating its bit pattern MSB-first, so full scale maps to 8'hFF.
  function automatic logic [7:0] expand_chan(input logic [7:0] raw, input int bits);
    logic [7:0] res;
    int         src;
    int         dst;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      src = bits - 1 - (i % bits);
      dst = 7 - i;
      res[dst[2:0]] = raw[src[2:0]];
    end
    return res;
  endfunction

endpackage

// File: rtl/vga_capture_fifo.sv
// First-word-fall-through synchronous FIFO with full/empty flags.
// The head entry is presented on rd_data whenever empty is low; rd_en
// pops it on the next edge. A write while full is accepted only when a
// pop happens on the same edge.
module vga_capture_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              do_wr, do_rd;

  // Flags, accepted push/pop and next pointer values
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || do_rd);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
    rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  // Pointer registers; reset empties the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/vga_frame_capture.sv
// VGA frame capture: watches the active-pixel and frame-end strobes,
// expands selected frames to 24-bit RGB and streams them out through a
// FWFT FIFO.
// Stream handshake: O_VALID is high whenever the FIFO holds a word; a
// word transfers on a rising edge where O_VALID && I_READY, and
// O_DATA/O_SOF/O_EOF hold stable while O_VALID && !I_READY.
module vga_frame_capture
  import vga_capture_pkg::*;
#(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int COLOR_BITS = 1,
  parameter int MAX_FRAMES = 25,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                I_CLK,
  input  logic                                I_RESET,
  input  logic                                I_PIX_VALID,
  input  logic                                I_FRAME_END,
  input  logic [3*COLOR_BITS-1:0]             I_RGB,
  input  logic [MAX_FRAMES-1:0]               I_CAPTURE_MASK,
  input  logic                                I_READY,
  output logic                                O_VALID,
  output logic [23:0]                         O_DATA,
  output logic                                O_SOF,
  output logic                                O_EOF,
  output logic [$clog2(MAX_FRAMES+1)-1:0]     O_FRAME_IDX,
  output logic                                O_OVERFLOW,
  output logic                                O_LEN_ERR,
  output logic                                O_DONE,
  output state_t                              O_DBG_STATE
);

  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int CNT_W = $clog2(NPIX + 1);
  localparam int IDX_W = $clog2(MAX_FRAMES + 1);

  localparam logic [CNT_W-1:0] NPIX_C = CNT_W'(NPIX);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NPIX - 1);
  localparam logic [IDX_W-1:0] MAXF_C = IDX_W'(MAX_FRAMES);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, next_idx;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               len_err_q, len_err_d;

  logic               mask_bit;
  logic [23:0]        rgb24;
  logic               push, pop;
  logic               fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] push_data, pop_data;

  // Channel expansion of the incoming pixel, R in the MSBs
  always_comb begin
    rgb24 = {expand_chan(8'(I_RGB[3*COLOR_BITS-1 -: COLOR_BITS]), COLOR_BITS),
             expand_chan(8'(I_RGB[2*COLOR_BITS-1 -: COLOR_BITS]), COLOR_BITS),
             expand_chan(8'(I_RGB[COLOR_BITS-1 -: COLOR_BITS]), COLOR_BITS)};
  end

  // Mask bit for the frame that starts after the current frame end
  always_comb begin
    next_idx = idx_q + IDX_W'(1);
    mask_bit = 1'b0;
    for (int i = 0; i < MAX_FRAMES; i++) begin
      if (next_idx == IDX_W'(i)) begin
        mask_bit = I_CAPTURE_MASK[i];
      end
    end
  end

  // FSM next state, pixel counter, push request and sticky error flags
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    len_err_d = len_err_q;
    push      = 1'b0;
    push_data = {(cnt_q == '0), (cnt_q == LAST_C), rgb24};
    pop       = !fifo_empty && I_READY;

    unique case (state_q)
      ST_SYNC: begin
        if (I_FRAME_END) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = I_CAPTURE_MASK[0] ? ST_CAPTURE : ST_SKIP;
        end
      end
      ST_SKIP, ST_CAPTURE: begin
        // A frame end on the same cycle as a pixel wins; the pixel is lost
        if (I_FRAME_END) begin
          if (cnt_q != NPIX_C) begin
            len_err_d = 1'b1;
          end
          cnt_d = '0;
          idx_d = next_idx;
          if (next_idx == MAXF_C) begin
            state_d = ST_DONE;
          end else begin
            state_d = mask_bit ? ST_CAPTURE : ST_SKIP;
          end
        end else if (I_PIX_VALID) begin
          if (cnt_q == NPIX_C) begin
            len_err_d = 1'b1;
          end else begin
            // Counter advances even if the FIFO drops the pixel, keeping
            // SOF/EOF tied to pixel position
            cnt_d = cnt_q + CNT_W'(1);
            push  = (state_q == ST_CAPTURE);
          end
        end
      end
      ST_DONE: begin
      end
      default: state_d = ST_SYNC;
    endcase

    if (push && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  // State and counter registers
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q   <= ST_SYNC;
      idx_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      len_err_q <= len_err_d;
    end
  end

  vga_capture_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk     (I_CLK),
    .rst     (I_RESET),
    .wr_en   (push),
    .wr_data (push_data),
    .rd_en   (pop),
    .rd_data (pop_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Output mapping
  always_comb begin
    O_VALID     = !fifo_empty;
    O_SOF       = pop_data[25];
    O_EOF       = pop_data[24];
    O_DATA      = pop_data[23:0];
    O_FRAME_IDX = idx_q;
    O_OVERFLOW  = ovf_q;
    O_LEN_ERR   = len_err_q;
    O_DONE      = (state_q == ST_DONE) && fifo_empty;
    O_DBG_STATE = state_q;
  end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture with a 4x2 frame, 2-bit channels,
// 3 frames and a 4-entry FIFO.
module tb_vga_frame_capture;
  import vga_capture_pkg::*;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int CB   = 2;
  localparam int MF   = 3;
  localparam int FD   = 4;
  localparam int NPIX = W * H;

  logic          clk;
  logic          rst;
  logic          pix_valid;
  logic          frame_end;
  logic [3*CB-1:0] rgb;
  logic [MF-1:0] mask;
  logic          ready;
  logic          o_valid;
  logic [23:0]   o_data;
  logic          o_sof;
  logic          o_eof;
  logic [1:0]    o_idx;
  logic          o_ovf;
  logic          o_len_err;
  logic          o_done;
  state_t        o_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_words  = 0;

  logic [25:0] exp_q[$];
  logic [25:0] mon_exp;

  vga_frame_capture #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .COLOR_BITS (CB),
    .MAX_FRAMES (MF),
    .FIFO_DEPTH (FD)
  ) dut (
    .I_CLK          (clk),
    .I_RESET        (rst),
    .I_PIX_VALID    (pix_valid),
    .I_FRAME_END    (frame_end),
    .I_RGB          (rgb),
    .I_CAPTURE_MASK (mask),
    .I_READY        (ready),
    .O_VALID        (o_valid),
    .O_DATA         (o_data),
    .O_SOF          (o_sof),
    .O_EOF          (o_eof),
    .O_FRAME_IDX    (o_idx),
    .O_OVERFLOW     (o_ovf),
    .O_LEN_ERR      (o_len_err),
    .O_DONE         (o_done),
    .O_DBG_STATE    (o_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference expansion for 2-bit channels: repeat each pair four times
  function automatic logic [23:0] model_rgb(input logic [5:0] p);
    return {{4{p[5:4]}}, {4{p[3:2]}}, {4{p[1:0]}}};
  endfunction

  // Scoreboard: every transferred word must match the head of exp_q
  always @(negedge clk) begin
    if (!rst && o_valid && ready) begin
      check("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check("stream_word", {6'b0, o_sof, o_eof, o_data}, {6'b0, mon_exp});
      end
      n_words++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    pix_valid = 1'b0;
    frame_end = 1'b0;
    tick();
    tick();
    exp_q.delete();
    rst = 1'b0;
    tick();
    n_words = 0;
  endtask

  task automatic drive_pix(input logic [5:0] px, input bit exp_push, input bit sof, input bit eof);
    pix_valid = 1'b1;
    rgb       = px;
    if (exp_push) exp_q.push_back({sof, eof, model_rgb(px)});
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic drive_frame_end();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  // pat 0: alternating white/black, pat 1: random pixels with random gaps
  task automatic send_frame(input int n, input bit captured, input int keep, input int pat);
    for (int i = 0; i < n; i++) begin
      logic [5:0] px;
      px = (pat == 0) ? ((i % 2 == 0) ? 6'h3F : 6'h00) : 6'($urandom_range(0, 63));
      drive_pix(px, captured && (i < NPIX) && (i < keep), i == 0, i == NPIX - 1);
      if (pat == 1) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    rst       = 1'b1;
    pix_valid = 1'b0;
    frame_end = 1'b0;
    rgb       = '0;
    mask      = '0;
    ready     = 1'b1;
    #2;
    sample();
    check("rst_valid", 32'(o_valid), 0);
    check("rst_data", 32'(o_data), 0);
    check("rst_sof", 32'(o_sof), 0);
    check("rst_eof", 32'(o_eof), 0);
    check("rst_idx", 32'(o_idx), 0);
    check("rst_ovf", 32'(o_ovf), 0);
    check("rst_len", 32'(o_len_err), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_state", 32'(o_state), 32'(ST_SYNC));

    // Capture frames 0 and 2, skip frame 1
    do_reset();
    mask = 3'b101;
    send_frame(3, 1'b0, 0, 1);            // pixels before sync are ignored
    drive_frame_end();
    sample();
    check("t1_idx0", 32'(o_idx), 0);
    check("t1_state0", 32'(o_state), 32'(ST_CAPTURE));
    send_frame(NPIX, 1'b1, NPIX, 0);
    drive_frame_end();
    sample();
    check("t1_idx1", 32'(o_idx), 1);
    check("t1_state1", 32'(o_state), 32'(ST_SKIP));
    check("t1_len0", 32'(o_len_err), 0);
    send_frame(NPIX, 1'b0, 0, 0);
    drive_frame_end();
    check("t1_done_early", 32'(o_done), 0);
    send_frame(NPIX, 1'b1, NPIX, 0);
    drive_frame_end();
    repeat (4) tick();
    sample();
    check("t1_done", 32'(o_done), 1);
    check("t1_idx3", 32'(o_idx), 3);
    check("t1_words", n_words, 16);
    check("t1_ovf", 32'(o_ovf), 0);
    check("t1_len", 32'(o_len_err), 0);
    drive_pix(6'h3F, 1'b0, 1'b0, 1'b0);   // ignored in DONE
    repeat (2) tick();
    check("t1_done_hold", 32'(o_done), 1);
    check("t1_drained", exp_q.size(), 0);

    // Expansion of {2'b10,2'b01,2'b11}, then random pixels
    do_reset();
    mask  = 3'b111;
    ready = 1'b0;
    drive_frame_end();
    drive_pix(6'b10_01_11, 1'b1, 1'b1, 1'b0);
    sample();
    check("t2_valid", 32'(o_valid), 1);
    check("t2_data", 32'(o_data), 32'h00AA55FF);
    check("t2_sof", 32'(o_sof), 1);
    tick();
    ready = 1'b1;
    for (int i = 1; i < NPIX; i++) begin
      logic [5:0] px;
      px = 6'($urandom_range(0, 63));
      drive_pix(px, 1'b1, 1'b0, i == NPIX - 1);
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (4) tick();
    check("t2_words", n_words, NPIX);
    check("t2_drained", exp_q.size(), 0);

    // Overflow: sink stalled for a whole frame
    do_reset();
    mask  = 3'b111;
    ready = 1'b0;
    drive_frame_end();
    send_frame(NPIX, 1'b1, FD, 1);
    sample();
    check("t3_ovf", 32'(o_ovf), 1);
    check("t3_valid", 32'(o_valid), 1);
    check("t3_head_sof", 32'(o_sof), 1);
    tick();
    drive_frame_end();
    ready = 1'b1;
    repeat (8) tick();
    check("t3_words", n_words, FD);
    check("t3_len", 32'(o_len_err), 0);
    check("t3_idx", 32'(o_idx), 1);
    check("t3_drained", exp_q.size(), 0);

    // Push and pop on the same edge while full
    do_reset();
    mask  = 3'b111;
    ready = 1'b0;
    drive_frame_end();
    for (int i = 0; i < FD; i++) drive_pix(6'($urandom_range(0, 63)), 1'b1, i == 0, 1'b0);
    ready = 1'b1;
    for (int i = FD; i < NPIX; i++) drive_pix(6'($urandom_range(0, 63)), 1'b1, 1'b0, i == NPIX - 1);
    repeat (6) tick();
    check("t4_ovf", 32'(o_ovf), 0);
    check("t4_words", n_words, NPIX);
    check("t4_drained", exp_q.size(), 0);

    // Short frame then long frame
    do_reset();
    mask  = 3'b111;
    drive_frame_end();
    send_frame(7, 1'b1, 7, 1);
    drive_frame_end();
    sample();
    check("t5_len_short", 32'(o_len_err), 1);
    check("t5_idx1", 32'(o_idx), 1);
    send_frame(9, 1'b1, NPIX, 1);
    drive_frame_end();
    repeat (4) tick();
    check("t5_idx2", 32'(o_idx), 2);
    check("t5_words", n_words, 7 + NPIX);
    check("t5_drained", exp_q.size(), 0);

    // Frame end coincident with a pixel
    do_reset();
    mask  = 3'b111;
    drive_frame_end();
    send_frame(NPIX, 1'b1, NPIX, 0);
    frame_end = 1'b1;
    pix_valid = 1'b1;
    rgb       = 6'h15;
    tick();
    frame_end = 1'b0;
    pix_valid = 1'b0;
    sample();
    check("t6_idx", 32'(o_idx), 1);
    send_frame(NPIX, 1'b1, NPIX, 1);
    drive_frame_end();
    repeat (4) tick();
    check("t6_len", 32'(o_len_err), 0);
    check("t6_words", n_words, 2 * NPIX);
    check("t6_drained", exp_q.size(), 0);

    // Reset in the middle of a capture with words queued
    do_reset();
    mask  = 3'b111;
    ready = 1'b0;
    drive_frame_end();
    send_frame(3, 1'b1, 3, 0);
    drive_frame_end();
    send_frame(2, 1'b1, 2, 0);
    sample();
    check("t7_pre_valid", 32'(o_valid), 1);
    check("t7_pre_idx", 32'(o_idx), 1);
    #1;
    rst = 1'b1;
    #1;
    check("t7_valid_now", 32'(o_valid), 0);
    check("t7_state", 32'(o_state), 32'(ST_SYNC));
    check("t7_idx", 32'(o_idx), 0);
    exp_q.delete();
    tick();
    sample();
    check("t7_valid_next", 32'(o_valid), 0);
    tick();
    rst     = 1'b0;
    ready   = 1'b1;
    n_words = 0;
    tick();
    drive_frame_end();
    sample();
    check("t7_restart_idx", 32'(o_idx), 0);
    check("t7_restart_state", 32'(o_state), 32'(ST_CAPTURE));
    send_frame(NPIX, 1'b1, NPIX, 1);
    repeat (4) tick();
    check("t7_words", n_words, NPIX);
    check("t7_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_frame_capture.md
# vga_frame_capture

Synthesizable successor to the simulation-only VGA frame dumper. It sits on the pixel clock beside the VGA output stage and watches the active-pixel strobe and the frame-end strobe. Frames selected by a capture mask are expanded to 24-bit RGB and pushed through a small FIFO onto a valid/ready stream for an external sink (UART/SD/debug RAM). Width, height, colour depth, frame count and FIFO depth are parameters; the block adds backpressure, overflow and frame-length checking.

## Interface
- WIDTH, 640, active pixels per line
- HEIGHT, 480, active lines per frame
- COLOR_BITS, 1, bits per channel on I_RGB (1..8)
- MAX_FRAMES, 25, frames observed before DONE
- FIFO_DEPTH, 16, FIFO entries (power of 2, ≥2)

- I_CLK  in  1  pixel clock (25 MHz); single clock domain
- I_RESET  in  1  asynchronous, active-high reset
- I_PIX_VALID  in  1  current pixel is in the visible area
- I_FRAME_END  in  1  one-cycle strobe, frame drawing finished
- I_RGB  in  3*COLOR_BITS  {R,G,B}, R in the MSBs
- I_CAPTURE_MASK  in  MAX_FRAMES  bit n=1 means capture frame n; sampled at each frame start
- I_READY  in  1  sink accepts the word
- O_VALID  out  1  O_DATA/O_SOF/O_EOF valid
- O_DATA  out  24  {R8,G8,B8}
- O_SOF  out  1  word is pixel 0 of a captured frame
- O_EOF  out  1  word is pixel WIDTH*HEIGHT-1
- O_FRAME_IDX  out  clog2(MAX_FRAMES+1)  current frame number
- O_OVERFLOW  out  1  sticky: pixel dropped because the FIFO was full
- O_LEN_ERR  out  1  sticky: a frame had the wrong pixel count
- O_DONE  out  1  MAX_FRAMES observed and FIFO drained

## Operation
- States: SYNC → (SKIP | CAPTURE) → DONE.
- SYNC: pixels are ignored. The first I_FRAME_END sets O_FRAME_IDX=0 and moves to CAPTURE if I_CAPTURE_MASK[0] is set, otherwise to SKIP.
- At each I_FRAME_END in SKIP/CAPTURE:
  - check the pixel count; a count ≠ WIDTH*HEIGHT sets O_LEN_ERR;
  - clear the pixel count;
  - increment O_FRAME_IDX;
  - if the new index equals MAX_FRAMES, go to DONE; otherwise choose CAPTURE or SKIP from the mask bit at the new index.
- Pixel counter: counts I_PIX_VALID in SKIP and CAPTURE. Pixels beyond WIDTH*HEIGHT are dropped, set O_LEN_ERR, and the counter saturates.
- CAPTURE: each counted pixel pushes {SOF, EOF, expanded RGB}.
  - Expansion: each channel's COLOR_BITS are replicated MSB-first to fill 8 bits (1 → 0xFF, 0 → 0x00; 2'b10 → 8'hAA).
- FIFO full while a push is requested, with no pop in the same cycle: the pixel is dropped and O_OVERFLOW is set. The pixel counter still advances, so SOF/EOF tagging stays positional.
- Simultaneous I_FRAME_END and I_PIX_VALID: the frame end wins and the pixel is ignored.
- DONE: inputs are ignored. O_DONE rises once the FIFO is empty and stays high until reset.
- Stream rule: O_VALID=!empty. A word transfers on an edge where O_VALID&&I_READY. O_DATA/O_SOF/O_EOF hold stable while O_VALID&&!I_READY.

## Timing
- Reset values: O_VALID=0, O_DATA=0, O_SOF=0, O_EOF=0, O_FRAME_IDX=0, O_OVERFLOW=0, O_LEN_ERR=0, O_DONE=0. FIFO is empty, state is SYNC.
- Reset asserted mid-frame or mid-stream: all of the above are restored immediately and FIFO contents are discarded.
- Latency: a pixel sampled at edge k is visible on O_DATA with O_VALID=1 after edge k (first-word fall-through, empty FIFO).
- Throughput: 1 word/cycle sustained while I_READY=1.
- Push and pop in the same cycle while full: the push is accepted and no overflow is flagged.
- O_FRAME_IDX updates on the edge that samples I_FRAME_END.
- The mask bit is read combinationally at that same edge.

## Structure
- Shared package/header vga_capture_pkg holds:
  - the state encoding (SYNC, SKIP, CAPTURE, DONE);
  - the channel-expansion function;
  - the FIFO entry width constant (26).
- One sub-module, vga_capture_fifo: parametrised first-word-fall-through synchronous FIFO (DEPTH, DATA_W) with full/empty flags and async reset. The top level holds the FSM, counters and expansion.

## Test plan
- WIDTH=4, HEIGHT=2, COLOR_BITS=1, mask=3'b101, MAX_FRAMES=3, I_READY=1, frames are alternating white/black pixels:
  - required: two bursts of 8 words, FF_FF_FF / 00_00_00 alternating;
  - SOF on word 0, EOF on word 7;
  - none for frame 1;
  - O_DONE after the third frame end.
- COLOR_BITS=2 pixel {2'b10,2'b01,2'b11} → O_DATA=24'hAA55FF.
- FIFO_DEPTH=4, I_READY=0 during an 8-pixel captured frame:
  - required: 4 words kept and O_OVERFLOW=1;
  - after I_READY=1, exactly 4 words come out, the first carrying SOF.
- A frame of 7 pixels, then a frame of 9 pixels: O_LEN_ERR=1 after the first frame end; the 9th pixel is not pushed.
- I_FRAME_END coincident with I_PIX_VALID: the pixel is not counted and O_FRAME_IDX increments by exactly 1.
- Assert I_RESET mid-capture with 3 words queued: O_VALID=0 on the next cycle, state is SYNC, and the next frame end restarts at O_FRAME_IDX=0.
